// File: rtl/image_pipeline_ctrl.sv
// Frame sequencer: LOAD -> GRAY -> STORE -> DONE, with a per-stage watchdog,
// a grayscale pixel-count check against the frame size, and registered status.
module image_pipeline_ctrl #(
  parameter int              N       = 450,
  parameter int              M       = 600,
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        load_done,
  input  logic        GS_valid,
  input  logic        GS_done,
  input  logic        store_done,
  output logic        load_en,
  output logic        GS_enable,
  output logic        store_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_GRAY  = 3'b010,
    S_STORE = 3'b011,
    S_DONE  = 3'b100,
    S_ERR   = 3'b101
  } state_e;

  localparam logic [18:0] FRAME_PIX = 19'(N * M);
  localparam logic [18:0] PIX_MAX   = '1;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wdog_q, wdog_d;
  logic [18:0]       pix_q, pix_d;
  logic [2:0]        err_q, err_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic [18:0]       pix_sum;
  logic              wd_exp;

  // Pixel total for this cycle already includes a GS_valid coincident with GS_done.
  assign pix_sum = (GS_valid && pix_q != PIX_MAX) ? pix_q + 19'd1 : pix_q;
  assign wd_exp  = (wdog_q == TIMEOUT - TO_W'(1));

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    pix_d   = pix_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    if (abort) begin
      state_d = S_IDLE;
      wdog_d  = '0;
      pix_d   = '0;
      err_d   = 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            wdog_d  = '0;
            pix_d   = '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state_d = S_GRAY;
            wdog_d  = '0;
          end else if (wd_exp) begin
            state_d = S_ERR;
            err_d   = 3'b001;
            wdog_d  = '0;
          end else begin
            wdog_d  = wdog_q + TO_W'(1);
          end
        end
        S_GRAY: begin
          pix_d = pix_sum;
          if (GS_done) begin
            wdog_d = '0;
            if (pix_sum == FRAME_PIX) begin
              state_d = S_STORE;
            end else begin
              state_d = S_ERR;
              err_d   = 3'b100;
            end
          end else if (wd_exp) begin
            state_d = S_ERR;
            err_d   = 3'b010;
            wdog_d  = '0;
          end else begin
            wdog_d  = wdog_q + TO_W'(1);
          end
        end
        S_STORE: begin
          if (store_done) begin
            state_d = S_DONE;
            wdog_d  = '0;
          end else if (wd_exp) begin
            state_d = S_ERR;
            err_d   = 3'b011;
            wdog_d  = '0;
          end else begin
            wdog_d  = wdog_q + TO_W'(1);
          end
        end
        S_DONE: begin
          fcnt_d  = fcnt_q + 16'd1;
          state_d = S_IDLE;
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      pix_q   <= '0;
      err_q   <= 3'b000;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign load_en   = (state_q == S_LOAD);
  assign GS_enable = (state_q == S_GRAY);
  assign store_en  = (state_q == S_STORE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_GRAY) || (state_q == S_STORE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign err_code  = err_q;
  assign frame_cnt = fcnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_image_pipeline_ctrl.sv
// Directed scenarios plus randomized traffic for image_pipeline_ctrl, checked
// every cycle against a behavioural model of the frame sequencer.
module tb_image_pipeline_ctrl;
  localparam int N = 2, M = 3, T = 16;

  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, load_done = 0, GS_valid = 0, GS_done = 0, store_done = 0;
  logic load_en, GS_enable, store_en, busy, done, error;
  logic [2:0] err_code, state;
  logic [15:0] frame_cnt;

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;
  bit seen_store;

  image_pipeline_ctrl #(.N(N), .M(M), .TO_W(24), .TIMEOUT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_done(load_done),
    .GS_valid(GS_valid), .GS_done(GS_done), .store_done(store_done),
    .load_en(load_en), .GS_enable(GS_enable), .store_en(store_en), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .frame_cnt(frame_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage codes are the state values the host sees; a stage's age is
  // the number of edges since it was entered.
  int m_state, m_err, m_fc, m_pix, m_enter, m_edge;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_err = 0; m_fc = 0; m_pix = 0; m_enter = 0; m_edge = 0;
    end else begin
      int nxt, age, tot;
      nxt = m_state;
      age = m_edge - m_enter;
      if (abort) begin
        nxt = 0; m_err = 0; m_pix = 0;
      end else if (m_state == 0) begin
        if (start) begin nxt = 1; m_pix = 0; end
      end else if (m_state == 1) begin
        if (load_done) nxt = 2;
        else if (age == T - 1) begin nxt = 5; m_err = 1; end
      end else if (m_state == 2) begin
        tot = m_pix + int'(GS_valid);
        if (tot > 524287) tot = 524287;
        m_pix = tot;
        if (GS_done) begin
          if (tot == N * M) nxt = 3;
          else begin nxt = 5; m_err = 4; end
        end else if (age == T - 1) begin nxt = 5; m_err = 2; end
      end else if (m_state == 3) begin
        if (store_done) nxt = 4;
        else if (age == T - 1) begin nxt = 5; m_err = 3; end
      end else if (m_state == 4) begin
        m_fc = (m_fc + 1) % 65536;
        nxt = 0;
      end
      if (nxt != m_state) m_enter = m_edge + 1;
      m_state = nxt;
      m_edge++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_state", int'(state), m_state);
      chk("m_status", int'({load_en, GS_enable, store_en, busy, done, error}),
          int'({m_state == 1, m_state == 2, m_state == 3,
                m_state >= 1 && m_state <= 3, m_state == 4, m_state == 5}));
      chk("m_err_code", int'(err_code), m_err);
      chk("m_frame_cnt", int'(frame_cnt), m_fc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (store_en) seen_store = 1;
    end
  endtask

  task automatic run_to_gray();
    start = 1; tick(1); start = 0;
    tick(2);
    load_done = 1; tick(1); load_done = 0;
  endtask

  task automatic pix(input int n);
    GS_valid = 1; tick(n); GS_valid = 0;
  endtask

  initial begin
    int cnt;
    tick(2);
    chk("reset_state", int'(state), 0);
    chk("reset_outs", int'({load_en, GS_enable, store_en, busy, done, error, err_code}), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    rst_n = 1;
    chk_on = 1;
    tick(1);

    // nominal frame
    start = 1; tick(1); start = 0;
    chk("start_load_en", int'({load_en, busy}), 3);
    tick(2);
    load_done = 1; tick(1); load_done = 0;
    pix(6);
    GS_done = 1; tick(1); GS_done = 0;
    chk("nominal_store", int'(state), 3);
    store_done = 1; tick(1); store_done = 0;
    chk("nominal_done", int'(done), 1);
    tick(1);
    chk("nominal_done_pulse", int'(done), 0);
    chk("nominal_frame_cnt", int'(frame_cnt), 1);
    chk("nominal_idle", int'({busy, err_code}), 0);

    // pixel mismatch
    seen_store = 0;
    run_to_gray();
    pix(5);
    GS_done = 1; tick(1); GS_done = 0;
    tick(2);
    chk("mismatch_state", int'(state), 5);
    chk("mismatch_error", int'(error), 1);
    chk("mismatch_code", int'(err_code), 4);
    chk("mismatch_no_store", int'(seen_store), 0);
    abort = 1; tick(1); abort = 0;
    chk("abort_state", int'(state), 0);
    chk("abort_code", int'(err_code), 0);

    // sixth pixel coincident with GS_done
    run_to_gray();
    pix(5);
    GS_valid = 1; GS_done = 1; tick(1); GS_valid = 0; GS_done = 0;
    chk("boundary_store", int'({state, error}), 6);
    store_done = 1; tick(2); store_done = 0;
    chk("boundary_frame_cnt", int'(frame_cnt), 2);

    // STORE timeout
    run_to_gray();
    pix(6);
    GS_done = 1; tick(1); GS_done = 0;
    cnt = 0;
    while (store_en === 1'b1 && cnt < 40) begin cnt++; tick(1); end
    chk("timeout_cycles", cnt, 16);
    chk("timeout_code", int'({error, err_code}), 11);
    abort = 1; tick(1); abort = 0;

    // completion in the last watchdog cycle wins
    run_to_gray();
    pix(6);
    GS_done = 1; tick(1); GS_done = 0;
    tick(15);
    store_done = 1; tick(1); store_done = 0;
    chk("late_done", int'({done, error}), 2);
    tick(1);
    chk("late_frame_cnt", int'(frame_cnt), 3);

    // priority and stray inputs
    start = 1; tick(1); start = 0;
    abort = 1; load_done = 1; tick(1); abort = 0; load_done = 0;
    chk("abort_over_load_done", int'(state), 0);
    run_to_gray();
    start = 1; load_done = 1; tick(1); start = 0; load_done = 0;
    chk("stray_in_gray", int'(state), 2);

    // reset mid-GRAY
    pix(3);
    #2 rst_n = 0;
    #1;
    chk("rst_gs_enable", int'(GS_enable), 0);
    chk("rst_outs", int'({state, load_en, store_en, busy, done, error, err_code}), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    tick(1);
    rst_n = 1;
    tick(1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      load_done  = ($urandom_range(0, 3) == 0);
      GS_valid   = ($urandom_range(0, 1) == 0);
      GS_done    = ($urandom_range(0, 5) == 0);
      store_done = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    {start, abort, load_done, GS_valid, GS_done, store_done} = '0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
